// File: rtl/mesh_term_pkg.sv
// Shared definitions for the mesh terminal agent: header field layout,
// RX state encoding and the destination check.
package mesh_term_pkg;

  // The routing header occupies the top HDR_W bits of every packet, whatever
  // the packet width. Positions below are bit indices inside that header slice,
  // which the agent takes as pkt[PCKG_SZ-1 -: HDR_W].
  localparam int HDR_W    = 17;
  localparam int NJ_MSB   = HDR_W - 1;
  localparam int ROW_MSB  = NJ_MSB - 8;
  localparam int COL_MSB  = ROW_MSB - 4;
  localparam int MODE_BIT = COL_MSB - 4;

  typedef logic [HDR_W-1:0] hdr_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_POP,
    RX_GAP
  } rx_state_t;

  // True when the packet belongs here: either a broadcast next-jump or an
  // exact row/column match with this terminal.
  function automatic logic dest_match(
    input hdr_t       pkt,
    input logic [3:0] row,
    input logic [3:0] col,
    input logic [7:0] bdcst
  );
    logic is_bdcst;
    logic is_mine;
    is_bdcst = (pkt[NJ_MSB -: 8] == bdcst);
    is_mine  = (pkt[ROW_MSB -: 4] == row) && (pkt[COL_MSB -: 4] == col);
    return is_bdcst || is_mine;
  endfunction

endpackage

// File: rtl/mesh_term_fifo.sv
// TX packet buffer: power-of-two synchronous FIFO with a count register so
// full/empty are plain registered decodes. Read and write may share a cycle.
module mesh_term_fifo #(
  parameter int PCKG_SZ    = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [PCKG_SZ-1:0] wr_data,
  input  logic               rd_en,
  output logic               full,
  output logic               empty,
  output logic [PCKG_SZ-1:0] head
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_V = CW'(FIFO_DEPTH);

  logic [PCKG_SZ-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               do_wr;
  logic               do_rd;

  assign full  = (count == DEPTH_V);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Storage is cleared on reset so the head presented to the mesh reads 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mesh_term_agent.sv
// Per-terminal agent: buffers host packets toward the mesh, ejects mesh
// packets into a one-entry holding register, and keeps counters/error flags.
module mesh_term_agent
  import mesh_term_pkg::*;
#(
  parameter int         PCKG_SZ    = 32,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [3:0] MY_ROW     = 4'd0,
  parameter logic [3:0] MY_COL     = 4'd0,
  parameter logic [7:0] BDCST      = 8'hFF,
  parameter int         TIMEOUT    = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_valid,
  input  logic [PCKG_SZ-1:0] tx_data,
  output logic               tx_ready,
  output logic [PCKG_SZ-1:0] data_out_i_in,
  output logic               pndng_i_in,
  input  logic               popin,
  input  logic [PCKG_SZ-1:0] data_out,
  input  logic               pndng,
  output logic               pop,
  output logic               rx_valid,
  output logic [PCKG_SZ-1:0] rx_data,
  input  logic               rx_ready,
  input  logic               clr,
  output logic [15:0]        tx_count,
  output logic [15:0]        rx_count,
  output logic               misroute,
  output logic               timeout,
  output logic               proto_err
);

  localparam int TO_W = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_PRE = TO_W'(TIMEOUT - 1);

  logic            full;
  logic            empty;
  logic            wr_en;
  logic            rd_en;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            capture;
  logic            mis_ev;
  logic            proto_ev;
  rx_state_t       state;
  rx_state_t       state_next;

  assign tx_ready   = !full;
  assign wr_en      = tx_valid && tx_ready;
  assign rd_en      = popin && !empty;
  assign pndng_i_in = !empty;

  mesh_term_fifo #(
    .PCKG_SZ    (PCKG_SZ),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (tx_data),
    .rd_en   (rd_en),
    .full    (full),
    .empty   (empty),
    .head    (data_out_i_in)
  );

  // Wait counter for the offered head: cleared by any popin or an empty FIFO,
  // otherwise counts up and parks at TIMEOUT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (popin || empty) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_hit   = pndng_i_in && !popin && (to_cnt >= TO_PRE);
  assign capture  = (state == RX_POP);
  assign mis_ev   = capture && !dest_match(data_out[PCKG_SZ-1 -: HDR_W], MY_ROW, MY_COL, BDCST);
  assign proto_ev = (popin && empty) || (capture && !pndng);

  // RX state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RX_IDLE;
    else        state <= state_next;
  end

  // RX sequencing: one pop, then a dead cycle before looking at pndng again.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      RX_IDLE: if (pndng && !rx_valid) state_next = RX_POP;
      RX_POP: begin
        pop        = 1'b1;
        state_next = RX_GAP;
      end
      RX_GAP:  state_next = RX_IDLE;
      default: state_next = RX_IDLE;
    endcase
  end

  // Holding register toward the host; the packet is kept even if misrouted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else if (capture) begin
      rx_valid <= 1'b1;
      rx_data  <= data_out;
    end else if (rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  // Packet counters; an event coinciding with clr leaves the count at 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_count <= '0;
      rx_count <= '0;
    end else begin
      if (rd_en)    tx_count <= clr ? 16'd1 : tx_count + 16'd1;
      else if (clr) tx_count <= '0;
      if (capture)  rx_count <= clr ? 16'd1 : rx_count + 16'd1;
      else if (clr) rx_count <= '0;
    end
  end

  // Sticky error flags; a setting event beats clr in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misroute  <= 1'b0;
      timeout   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (mis_ev)        misroute  <= 1'b1;
      else if (clr)      misroute  <= 1'b0;
      if (to_hit)        timeout   <= 1'b1;
      else if (clr)      timeout   <= 1'b0;
      if (proto_ev)      proto_err <= 1'b1;
      else if (clr)      proto_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mesh_term_agent.sv
// Directed bench for mesh_term_agent at row 4, column 5 with default sizes.
module tb_mesh_term_agent;

  localparam int P = 32;
  localparam int TIMEOUT = 1023;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         tx_valid = 1'b0;
  logic [P-1:0] tx_data = '0;
  logic         tx_ready;
  logic [P-1:0] data_out_i_in;
  logic         pndng_i_in;
  logic         popin = 1'b0;
  logic [P-1:0] data_out = '0;
  logic         pndng = 1'b0;
  logic         pop;
  logic         rx_valid;
  logic [P-1:0] rx_data;
  logic         rx_ready = 1'b0;
  logic         clr = 1'b0;
  logic [15:0]  tx_count;
  logic [15:0]  rx_count;
  logic         misroute;
  logic         timeout;
  logic         proto_err;

  int checks = 0;
  int failures = 0;
  logic [5:0] pat;
  logic       any_pop;

  mesh_term_agent #(
    .PCKG_SZ    (P),
    .FIFO_DEPTH (8),
    .MY_ROW     (4'd4),
    .MY_COL     (4'd5),
    .BDCST      (8'hFF),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .data_out_i_in (data_out_i_in),
    .pndng_i_in    (pndng_i_in),
    .popin         (popin),
    .data_out      (data_out),
    .pndng         (pndng),
    .pop           (pop),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .clr           (clr),
    .tx_count      (tx_count),
    .rx_count      (rx_count),
    .misroute      (misroute),
    .timeout       (timeout),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [31:0] pkt);
    tx_valid = 1'b1;
    tx_data  = pkt;
    tick();
    tx_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    checkOutput("rst_flags", {31'd0, tx_ready}, 32'd1);
    checkOutput("rst_ctl", {26'd0, pndng_i_in, pop, rx_valid, misroute, timeout, proto_err}, 32'd0);
    checkOutput("rst_head", data_out_i_in, 32'd0);
    checkOutput("rst_cnt", {tx_count, rx_count}, 32'd0);
    reset = 1'b1;
    tick();

    // Single injection, popin on the third cycle of the offer
    applyStimulus(32'h0045_D52A);
    checkOutput("tx1_pndng", {31'd0, pndng_i_in}, 32'd1);
    checkOutput("tx1_head", data_out_i_in, 32'h0045_D52A);
    tick();
    tick();
    checkOutput("tx1_hold", {31'd0, pndng_i_in}, 32'd1);
    popin = 1'b1;
    tick();
    popin = 1'b0;
    checkOutput("tx1_drop", {31'd0, pndng_i_in}, 32'd0);
    checkOutput("tx1_count", {16'd0, tx_count}, 32'd1);

    // Fill to full, pop while the host keeps offering
    for (int i = 0; i < 8; i++) applyStimulus(32'hA000_0000 + i);
    checkOutput("full_ready", {31'd0, tx_ready}, 32'd0);
    checkOutput("full_head", data_out_i_in, 32'hA000_0000);
    tx_valid = 1'b1;
    tx_data  = 32'hA000_0008;
    popin    = 1'b1;
    checkOutput("full_ready_pop", {31'd0, tx_ready}, 32'd0);
    tick();
    popin = 1'b0;
    tick();
    tx_valid = 1'b0;
    checkOutput("full_again", {31'd0, tx_ready}, 32'd0);
    checkOutput("full_count", {16'd0, tx_count}, 32'd2);
    for (int i = 1; i <= 8; i++) begin
      checkOutput($sformatf("drain%0d", i), data_out_i_in, 32'hA000_0000 + i);
      popin = 1'b1;
      tick();
    end
    popin = 1'b0;
    checkOutput("drain_empty", {31'd0, pndng_i_in}, 32'd0);
    checkOutput("drain_count", {16'd0, tx_count}, 32'd10);
    checkOutput("drain_perr", {31'd0, proto_err}, 32'd0);

    // RX streaming with the host always ready: one pop every 3 cycles
    pndng    = 1'b1;
    data_out = 32'h0045_8001;
    rx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      pat[5-i] = pop;
      if (i == 1) begin
        checkOutput("rx_valid", {31'd0, rx_valid}, 32'd1);
        checkOutput("rx_data", rx_data, 32'h0045_8001);
      end
    end
    pndng = 1'b0;
    checkOutput("rx_pop_pattern", {26'd0, pat}, 32'b100100);
    checkOutput("rx_count2", {16'd0, rx_count}, 32'd2);
    checkOutput("rx_mis0", {31'd0, misroute}, 32'd0);

    // Misrouted packet is flagged and still delivered
    pndng    = 1'b1;
    data_out = 32'h0012_0000;
    rx_ready = 1'b0;
    tick();
    tick();
    pndng = 1'b0;
    checkOutput("mis_flag", {31'd0, misroute}, 32'd1);
    checkOutput("mis_data", rx_data, 32'h0012_0000);
    tick();
    // Backpressure: held packet blocks further pops
    pndng    = 1'b1;
    data_out = 32'hFF12_0000;
    any_pop  = 1'b0;
    tick();
    any_pop |= pop;
    tick();
    any_pop |= pop;
    checkOutput("bp_nopop", {31'd0, any_pop}, 32'd0);
    checkOutput("bp_valid", {31'd0, rx_valid}, 32'd1);
    rx_ready = 1'b1;
    tick();
    checkOutput("bp_release", {30'd0, rx_valid, misroute}, 32'b01);
    checkOutput("rx_count3", {16'd0, rx_count}, 32'd3);
    tick();
    checkOutput("bc_pop", {31'd0, pop}, 32'd1);
    clr = 1'b1;
    tick();
    clr      = 1'b0;
    pndng    = 1'b0;
    rx_ready = 1'b0;
    checkOutput("bc_mis_clr", {31'd0, misroute}, 32'd0);
    checkOutput("clr_rx_event", {16'd0, rx_count}, 32'd1);
    checkOutput("clr_tx", {16'd0, tx_count}, 32'd0);
    checkOutput("bc_data", rx_data, 32'hFF12_0000);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;

    // Timeout after exactly TIMEOUT cycles of unanswered offer
    applyStimulus(32'h0045_0000);
    repeat (TIMEOUT - 1) tick();
    checkOutput("to_before", {31'd0, timeout}, 32'd0);
    tick();
    checkOutput("to_at", {31'd0, timeout}, 32'd1);
    checkOutput("to_perr0", {31'd0, proto_err}, 32'd0);
    popin = 1'b1;
    tick();
    tick();
    popin = 1'b0;
    checkOutput("perr_empty_pop", {31'd0, proto_err}, 32'd1);
    checkOutput("perr_txcount", {16'd0, tx_count}, 32'd1);

    // Asynchronous reset in the middle of an offer and an RX pop
    applyStimulus(32'h0045_0001);
    pndng    = 1'b1;
    data_out = 32'h0045_7777;
    tick();
    checkOutput("ar_pop_before", {31'd0, pop}, 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("ar_ctl", {25'd0, pop, pndng_i_in, tx_ready, rx_valid, misroute, timeout, proto_err},
                32'b0010000);
    checkOutput("ar_cnt", {tx_count, rx_count}, 32'd0);
    checkOutput("ar_data", data_out_i_in | rx_data, 32'd0);
    pndng = 1'b0;
    @(negedge clk);
    reset   = 1'b1;
    any_pop = 1'b0;
    repeat (3) begin
      tick();
      any_pop |= pop;
    end
    checkOutput("ar_nopop", {30'd0, any_pop, pndng_i_in}, 32'd0);
    pndng = 1'b1;
    tick();
    checkOutput("ar_resume", {31'd0, pop}, 32'd1);
    pndng = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
